// File: rtl/ic_pkg.sv
// Shared constants and helpers for the 2504/2519 shift-register bank.
package ic_pkg;

    localparam int unsigned DEPTH_2504    = 1024;
    localparam int unsigned CHANNELS_2504 = 6;
    localparam int unsigned DEPTH_2519    = 40;
    localparam int unsigned CHANNELS_2519 = 6;

    // Pointer width that stays at least one bit for tiny depths.
    function automatic int unsigned ptr_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/ic_shift_ram.sv
// Single-port read-before-write synchronous RAM; we=0 on an access leaves the word intact.
module ic_shift_ram #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Storage array has no reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (en) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ic_2504_bank.sv
// Bank of recirculating serial shift registers built on a circular RAM with a position counter.
module ic_2504_bank
    import ic_pkg::*;
#(
    parameter int unsigned          CHANNELS    = CHANNELS_2504,
    parameter int unsigned          DEPTH       = DEPTH_2504,
    parameter logic [CHANNELS-1:0]  INVERT_MASK = '0,
    localparam int unsigned         PW          = ptr_width(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                shift_en,
    input  logic                recirc,
    input  logic [CHANNELS-1:0] d,
    output logic [CHANNELS-1:0] q,
    output logic [PW-1:0]       pos,
    output logic                wrap,
    output logic                valid
);

    localparam logic [PW-1:0] POS_LAST = PW'(DEPTH - 1);

    logic                shift_c;
    logic                last_c;
    logic [PW-1:0]       pos_d;
    logic [PW-1:0]       pos_q;
    logic                wrap_q;
    logic                valid_q;
    logic [CHANNELS-1:0] ram_rdata;

    assign shift_c = shift_en & ~reset;
    assign last_c  = (pos_q == POS_LAST);

    // Explicit compare-and-clear so non-power-of-two depths wrap cleanly.
    always_comb begin
        pos_d = pos_q;
        if (shift_c) begin
            pos_d = last_c ? '0 : pos_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q   <= '0;
            wrap_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            pos_q  <= pos_d;
            wrap_q <= shift_c & last_c;
            if (shift_c && last_c) begin
                valid_q <= 1'b1;
            end
        end
    end

    // Recirculation is simply a read with the write suppressed.
    ic_shift_ram #(
        .WIDTH (CHANNELS),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_ram (
        .clk   (clk),
        .rst   (reset),
        .en    (shift_c),
        .we    (~recirc),
        .addr  (pos_q),
        .wdata (d),
        .rdata (ram_rdata)
    );

    assign q     = ram_rdata ^ INVERT_MASK;
    assign pos   = pos_q;
    assign wrap  = wrap_q;
    assign valid = valid_q;

endmodule

// File: doc/ic_2504_bank.md
# ic_2504_bank

Parametrised bank of recirculating serial shift registers modelling the terminal's 2504/2519 dynamic shift-register video memory. It sits between the character input path and the character ROM addressing logic. It generalises the hex-inverter cell into a multi-channel, configurable-depth storage element:

- Per-channel output polarity inversion is folded in.
- Load or recirculate mode is selectable.
- A position counter and wrap/valid status are provided for video timing.

## Interface

Parameters:
- CHANNELS, 6, number of parallel 1-bit shift registers (≥1)
- DEPTH, 1024, bits per channel (≥2; non-power-of-two allowed)
- INVERT_MASK, 0, CHANNELS-bit mask; bit i = 1 inverts channel i output (7404 stage on q)

Ports:
- clk  input  1  sole clock, rising-edge
- reset  input  1  synchronous, active-high; priority over all other inputs
- shift_en  input  1  one shift on every clk edge where high
- recirc  input  1  1: tail bit re-enters head; 0: d enters head
- d  input  CHANNELS  serial input, one bit per channel
- q  output  CHANNELS  bit leaving the tail, XOR INVERT_MASK, registered
- pos  output  PW  current position, PW = max(1, $clog2(DEPTH))
- wrap  output  1  one-cycle pulse after the shift that returns pos to 0
- valid  output  1  sticky; high once DEPTH shifts have completed since reset

## Operation

- Storage is a DEPTH × CHANNELS circular buffer addressed by pos. No physical shifting takes place.
- On a shift (shift_en=1, reset=0), all of the following happen at the same edge:
  - Read mem[pos] (old value, read-before-write).
  - Write mem[pos] ← recirc ? mem[pos] : d.
  - q ← old mem[pos] ^ INVERT_MASK.
  - pos ← (pos == DEPTH-1) ? 0 : pos+1.
- Net behaviour: a bit entering on shift k leaves on q at shift k+DEPTH. Recirculation preserves the stored pattern indefinitely.
- shift_en=0: mem, q, pos and valid hold; wrap ← 0.
- wrap ← 1 exactly on a shift with pos == DEPTH-1, else 0.
- valid ← 1 on the same edge as the first wrap after reset; it stays 1 until reset.
- recirc and d are sampled only on shift edges. Changing recirc between shifts is legal and takes effect on the next shift.

## Timing

- Reset values (edge with reset=1, regardless of shift_en):
  - pos=0
  - q=INVERT_MASK (raw 0)
  - wrap=0
  - valid=0
- Memory contents are not cleared by reset; they initialise to 0 at configuration only.
- Reset mid-operation: contents are retained but the alignment to pos is lost. valid drops, and q is not meaningful until valid re-asserts.
- Latency d→q: DEPTH shifts. q changes only on shift edges.
- pos/wrap/valid are registered; all update on the same edge.
- Back-to-back shifts every cycle are supported. There is no handshake and no stall.
- The boundary DEPTH-1 → 0 must not drop or duplicate a bit, including for non-power-of-two DEPTH.

## Structure

- Shared package ic_pkg holds:
  - the pointer-width function (max(1,$clog2(n)))
  - the default DEPTH/CHANNELS constants for the 2504 (1024×6) and 2519 (40×6) configurations
- Sub-module ic_shift_ram: single-port, read-before-write synchronous RAM, DEPTH × CHANNELS, with a write-enable input.
- The top level holds the pos counter, the wrap/valid logic and the polarity XOR.

## Test plan

- DEPTH=4, CHANNELS=2, INVERT_MASK=0:
  - Stimulus: reset, then shift d=1,2,3,0 with recirc=0, then shift 4 more times.
  - Required: q=1,2,3,0 on shifts 5–8; wrap high after shifts 4 and 8; valid high from shift 4.
- Same config, recirculate:
  - Stimulus: load 1,2,3,0, then 8 shifts with recirc=1 and d=3.
  - Required: q repeats 1,2,3,0,1,2,3,0; d is ignored.
- INVERT_MASK=2'b10:
  - Stimulus: reset.
  - Required: q=2'b10. After loading 0,0,0,0 and shifting, q=2'b10; loaded 3 emerges as 1.
- shift_en gaps:
  - Stimulus: random shift_en at about 50% over 100 cycles against a reference queue model.
  - Required: q/pos match the model; state holds during idle cycles; wrap never high twice in a row.
- Reset mid-operation:
  - Stimulus: assert reset at pos=2 with shift_en=1.
  - Required: pos=0, valid=0, wrap=0, q=INVERT_MASK next cycle; valid returns after exactly 4 further shifts.
- DEPTH=40 (2519 config):
  - Stimulus: stream 40-entry pattern, then recirculate 200 shifts.
  - Required: pattern is preserved; wrap pulses every 40 shifts; pos never exceeds 39.
